// File: rtl/mem_access_unit.sv
// Memory access unit: runs one req/ack transaction on the unified memory port
// with byte-lane steering, alignment checks, ack timeout and a held load result.
module mem_access_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic                  i_start,
  input  logic                  i_we,
  input  logic [1:0]            i_size,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  output logic [3:0]            o_mem_be,
  input  logic                  i_mem_ack,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_REQ  = 2'b01;
  localparam logic [1:0] ST_RESP = 2'b10;
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  function automatic logic is_bad(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   is_bad = 1'b0;
      2'b01:   is_bad = off[0];
      2'b10:   is_bad = (off != 2'b00);
      default: is_bad = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] calc_be(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   calc_be = 4'b0001 << off;
      2'b01:   calc_be = 4'b0011 << off;
      2'b10:   calc_be = 4'b1111;
      default: calc_be = 4'b0000;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] lane_wdata(input logic [1:0] size,
                                                       input logic [DATA_WIDTH-1:0] wd);
    case (size)
      2'b00:   lane_wdata = {4{wd[7:0]}};
      2'b01:   lane_wdata = {2{wd[15:0]}};
      default: lane_wdata = wd;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] align_rdata(input logic [1:0] size,
                                                        input logic [1:0] off,
                                                        input logic [DATA_WIDTH-1:0] rd);
    logic [DATA_WIDTH-1:0] sh;
    sh = rd >> {off, 3'b000};
    case (size)
      2'b00:   align_rdata = {{(DATA_WIDTH-8){1'b0}}, sh[7:0]};
      2'b01:   align_rdata = {{(DATA_WIDTH-16){1'b0}}, sh[15:0]};
      default: align_rdata = sh;
    endcase
  endfunction

  logic [1:0]            state_r;
  logic [7:0]            cnt_r;
  logic [1:0]            off_r;
  logic [1:0]            size_r;
  logic                  we_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  err_r;
  logic [DATA_WIDTH-1:0] rdata_r;
  logic                  mem_req_r;
  logic                  mem_we_r;
  logic [ADDR_WIDTH-1:0] mem_addr_r;
  logic [DATA_WIDTH-1:0] mem_wdata_r;
  logic [3:0]            mem_be_r;

  logic                  start_bad_s;
  logic                  req_exit_s;

  // Decode request legality and the REQ exit condition (ack or timeout).
  always_comb begin
    start_bad_s = is_bad(i_size, i_addr[1:0]);
    req_exit_s  = i_mem_ack || (cnt_r == TIMEOUT_C);
  end

  // Transaction FSM; every output is a register, memory outputs live only in REQ.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 8'd0;
      off_r       <= 2'b00;
      size_r      <= 2'b00;
      we_r        <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      rdata_r     <= '0;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      mem_be_r    <= 4'b0000;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (i_start) begin
            off_r  <= i_addr[1:0];
            size_r <= i_size;
            we_r   <= i_we;
            cnt_r  <= 8'd0;
            if (start_bad_s) begin
              state_r <= ST_RESP;
              done_r  <= 1'b1;
              err_r   <= 1'b1;
            end else begin
              state_r     <= ST_REQ;
              busy_r      <= 1'b1;
              mem_req_r   <= 1'b1;
              mem_we_r    <= i_we;
              mem_addr_r  <= {i_addr[ADDR_WIDTH-1:2], 2'b00};
              mem_wdata_r <= lane_wdata(i_size, i_wdata);
              mem_be_r    <= calc_be(i_size, i_addr[1:0]);
            end
          end
        end
        ST_REQ: begin
          if (req_exit_s) begin
            state_r     <= ST_RESP;
            done_r      <= 1'b1;
            err_r       <= !i_mem_ack;
            busy_r      <= 1'b0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            mem_be_r    <= 4'b0000;
            // Ack wins over a same-cycle timeout; stores leave the load result alone.
            if (i_mem_ack && !we_r) begin
              rdata_r <= align_rdata(size_r, off_r, i_mem_rdata);
            end
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        ST_RESP: state_r <= ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign o_busy      = busy_r;
  assign o_done      = done_r;
  assign o_err       = err_r;
  assign o_rdata     = rdata_r;
  assign o_mem_req   = mem_req_r;
  assign o_mem_we    = mem_we_r;
  assign o_mem_addr  = mem_addr_r;
  assign o_mem_wdata = mem_wdata_r;
  assign o_mem_be    = mem_be_r;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory access unit for the multicycle core. It latches the address chosen by the memory-address mux (PC next or ALU result) together with the access size and write data. It runs one request/acknowledge transaction on the unified instruction/data memory port, returns aligned read data to the datapath in a held register, and reports completion, misalignment or timeout to the main control FSM.

## Interface
- `ADDR_WIDTH`, 32, byte-address width.
- `DATA_WIDTH`, 32, memory word width; must be 32 (4 byte lanes, offset = `addr[1:0]`).
- `TIMEOUT`, 255, maximum wait cycles for `i_mem_ack` (8-bit counter).

Ports (clock and reset first):
- `clk`  in  1  single clock, rising edge.
- `arstn`  in  1  asynchronous, active-low reset.
- `i_start`  in  1  one-cycle request from the control FSM; ignored unless state is IDLE.
- `i_we`  in  1  1 = store, 0 = load.
- `i_size`  in  2  access size: 00 = byte, 01 = half, 10 = word; 11 is illegal.
- `i_addr`  in  ADDR_WIDTH  byte address from the address mux.
- `i_wdata`  in  DATA_WIDTH  store data, right-aligned.
- `o_busy`  out  1  high in the REQ state.
- `o_done`  out  1  one-cycle completion pulse.
- `o_err`  out  1  valid with `o_done`: misaligned, illegal size or timeout.
- `o_rdata`  out  DATA_WIDTH  load data, right-aligned and zero-extended; held until the next successful load.
- `o_mem_req`  out  1  memory request.
- `o_mem_we`  out  1  memory write enable.
- `o_mem_addr`  out  ADDR_WIDTH  word-aligned address (`addr[1:0]` = 0).
- `o_mem_wdata`  out  DATA_WIDTH  store data shifted to the byte lane.
- `o_mem_be`  out  4  byte enables.
- `i_mem_ack`  in  1  memory acknowledge; read data is valid in the same cycle.
- `i_mem_rdata`  in  DATA_WIDTH  memory read word.

## Operation
- State machine states: IDLE, REQ, RESP.
- **IDLE**
  - On `i_start`, register `i_addr`, `i_we`, `i_size` and `i_wdata`.
  - Check alignment: half requires `addr[0]`=0, word requires `addr[1:0]`=0, size 11 is illegal.
  - Error → RESP with the error flag set, and no memory request is issued.
  - OK → REQ, with the wait counter cleared.
- **REQ**
  - Drive `o_mem_req`=1 and hold all `o_mem_*` outputs stable.
  - On `i_mem_ack`: for a load, capture `o_rdata`; then → RESP with no error.
  - When the counter reaches `TIMEOUT` without an ack: → RESP with the error flag set; `o_rdata` is unchanged.
- **RESP**: assert `o_done`=1 (and `o_err` as flagged), then → IDLE.
- Byte enables: byte = `4'b0001 << off`; half = `4'b0011 << off`; word = `4'b1111`.
- Write data: `o_mem_wdata` = `i_wdata` replicated to lanes, i.e. byte → {4{b}}, half → {2{h}}, word → w.
- Read data: `o_rdata` = (`i_mem_rdata >> 8*off`), masked to 8/16/32 bits, upper bits zero. Sign extension is done downstream.
- `o_mem_addr` = {`addr[ADDR_WIDTH-1:2]`, 2'b00}.
- `o_mem_*` outputs are 0 outside REQ.
- A store never modifies `o_rdata`.

## Timing
- Reset (async, `arstn`=0): state IDLE; `o_busy`, `o_done`, `o_err`, `o_mem_req` and `o_mem_we` are 0; `o_mem_addr`, `o_mem_wdata`, `o_mem_be`, `o_rdata` and the counter are 0.
  - Reset mid-transaction drops `o_mem_req` immediately and produces no `o_done`.
- Latency:
  - `i_start` sampled at edge N → `o_mem_req` high in cycle N+1.
  - Ack sampled at edge M → `o_done` in cycle M+1, and `o_rdata` valid from M+1.
  - With zero-wait memory (ack in the first REQ cycle), `o_done` is in cycle N+2.
- Error path: `i_start` at edge N → `o_done`=`o_err`=1 in cycle N+1, with no request.
- Timeout: `o_done`/`o_err` arrive `TIMEOUT`+2 cycles after start.
- `i_start` in REQ or RESP is dropped; it is not queued.
- `i_mem_ack` outside REQ is ignored.
- Back-to-back: a new `i_start` is accepted in the cycle after `o_done`.

## Test plan
- **Reset:** assert `arstn`=0 mid-REQ → `o_mem_req`=0 immediately; all outputs 0; no `o_done` after release.
- **Word load, zero-wait:** `i_addr`=0x100, size=10, ack in the first REQ cycle with rdata=0xDEADBEEF.
  - `o_mem_addr`=0x100, `o_mem_be`=1111.
  - `o_done` at N+2, `o_rdata`=0xDEADBEEF, `o_err`=0.
- **Byte load at offset 3:** `i_addr`=0x203, rdata=0xA1B2C3D4, ack after 3 wait cycles.
  - `o_mem_addr`=0x200, `o_mem_be`=1000.
  - `o_rdata`=0x000000A1, `o_done` 1 cycle after ack.
- **Half store at offset 2:** `i_wdata`=0x0000BEEF.
  - `o_mem_we`=1, `o_mem_be`=1100, `o_mem_wdata`=0xBEEFBEEF.
  - `o_rdata` unchanged.
- **Misaligned or illegal:** word at 0x102, half at 0x101, and size 11.
  - Each gives `o_done`=`o_err`=1 at N+1; `o_mem_req` never asserted.
- **Timeout and ignored start:** `TIMEOUT`=4, ack never asserted, second `i_start` pulsed during REQ.
  - `o_err`/`o_done` at N+6.
  - Only one transaction occurs; the next start is accepted after `o_done`.
